// File: rtl/fetch_buf_stage.sv
// Instruction fetch stage: variable-latency SRAM-like fetch port feeding an in-order buffer towards ID.
// Optional FETCH_BYPASS_EN forwards a response to ID in its arrival cycle when it belongs to the head entry.
module fetch_buf_stage #(
    parameter logic [31:0] RESET_PC   = 32'h1c000000,
    parameter int          IBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allow_in,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    input  logic [32:0] br_bus,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    localparam int            AW      = $clog2(IBUF_DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW:0]   DEPTH_X = (CW+1)'(IBUF_DEPTH);

    logic [31:0]           buf_pc   [IBUF_DEPTH];
    logic [31:0]           buf_inst [IBUF_DEPTH];
    logic [IBUF_DEPTH-1:0] filled;
    logic [AW-1:0]         head;
    logic [AW-1:0]         fill;
    logic [AW-1:0]         tail;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         pend;
    logic [CW-1:0]         discard_cnt;
    logic [31:0]           fetch_pc;

    logic        br_taken;
    logic [31:0] br_target;
    logic        hs;
    logic        acc;
    logic        drop;
    logic        pop;
    logic        head_filled;
    logic        bypass;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    // Request side: stale responses still occupy memory-side slots, so they count against the depth.
    assign inst_req  = resetn & ~br_taken &
                       (({1'b0, cnt} + {1'b0, discard_cnt}) < DEPTH_X);
    assign inst_addr = fetch_pc;
    assign hs        = inst_req & inst_addr_ok;
    assign drop      = inst_data_ok & (discard_cnt != '0);
    assign acc       = inst_data_ok & (discard_cnt == '0);

    assign head_filled = (cnt != '0) & filled[head];
`ifdef FETCH_BYPASS_EN
    assign bypass = (cnt != '0) & (head == fill) & ~filled[head] & acc;
`else
    assign bypass = 1'b0;
`endif

    // Delivery side
    assign fs_to_ds_valid = resetn & (head_filled | bypass);
    assign fs_to_ds_bus   = {buf_pc[head], bypass ? inst_rdata : buf_inst[head]};
    assign pop            = fs_to_ds_valid & ds_allow_in;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc    <= RESET_PC;
            head        <= '0;
            fill        <= '0;
            tail        <= '0;
            cnt         <= '0;
            pend        <= '0;
            discard_cnt <= '0;
            filled      <= '0;
        end else if (br_taken) begin
            // Every unfilled entry becomes a response to throw away; one may be arriving right now.
            fetch_pc    <= br_target;
            head        <= '0;
            fill        <= '0;
            tail        <= '0;
            cnt         <= '0;
            pend        <= '0;
            discard_cnt <= discard_cnt + pend - CW'(inst_data_ok);
        end else begin
            if (hs) begin
                tail         <= tail + AW'(1);
                filled[tail] <= 1'b0;
                fetch_pc     <= fetch_pc + 32'd4;
            end
            if (acc) begin
                fill <= fill + AW'(1);
                if (!(bypass && pop))
                    filled[fill] <= 1'b1;
            end
            if (pop)
                head <= head + AW'(1);
            cnt         <= cnt + CW'(hs) - CW'(pop);
            pend        <= pend + CW'(hs) - CW'(acc);
            discard_cnt <= discard_cnt - CW'(drop);
        end
    end

    // Buffer payload carries no reset; the filled bits and count qualify it.
    always_ff @(posedge clk) begin
        if (hs)
            buf_pc[tail] <= fetch_pc;
        if (acc)
            buf_inst[fill] <= inst_rdata;
    end

endmodule

// File: tb/tb_fetch_buf_stage.sv
// Directed bench for fetch_buf_stage with an in-order memory model; the response word is pc ^ 32'hdeadbeef.
module tb_fetch_buf_stage;

    localparam logic [31:0] BASE = 32'h1c000000;
    localparam logic [31:0] KEY  = 32'hdeadbeef;
`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ds_allow_in = 1'b0;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic [32:0] br_bus = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;

    fetch_buf_stage #(.RESET_PC(BASE), .IBUF_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .ds_allow_in(ds_allow_in),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .br_bus(br_bus), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mq_a[$];
    int          mq_t[$];
    logic [31:0] reqs[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];
    bit          mem_hold = 0;
    bit          rnd = 0;
    bit          live_chk = 0;
    logic        s_req, s_valid, s_dok;
    logic [31:0] s_addr;
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    int          n0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive memory response, sample outputs mid-cycle, advance past the edge.
    task automatic cycle();
        logic [31:0] a;
        inst_data_ok = 1'b0;
        if (!mem_hold && mq_a.size() > 0 && cyc >= mq_t[0] &&
            (!rnd || $urandom_range(0, 3) != 0)) begin
            a = mq_a.pop_front();
            n0 = mq_t.pop_front();
            inst_data_ok = 1'b1;
            inst_rdata   = a ^ KEY;
        end
        if (rnd) begin
            inst_addr_ok = ($urandom_range(0, 2) != 0);
            ds_allow_in  = ($urandom_range(0, 2) != 0);
        end
        #1;
        s_req = inst_req; s_addr = inst_addr; s_valid = fs_to_ds_valid; s_dok = inst_data_ok;
        if (resetn && inst_req && inst_addr_ok) begin
            mq_a.push_back(inst_addr);
            mq_t.push_back(cyc + 1 + (rnd ? int'($urandom_range(0, 4)) : 0));
            reqs.push_back(inst_addr);
        end
        if (fs_to_ds_valid && ds_allow_in && !br_bus[32]) begin
            got_pc.push_back(fs_to_ds_bus[63:32]);
            got_inst.push_back(fs_to_ds_bus[31:0]);
            if (live_chk) begin
                chk("rnd_pc", 64'(fs_to_ds_bus[63:32]), 64'(exp_pc));
                chk("rnd_inst", 64'(fs_to_ds_bus[31:0]), 64'(exp_pc ^ KEY));
                exp_pc = exp_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        resetn = 1'b0; br_bus = '0; ds_allow_in = 1'b0; inst_addr_ok = 1'b0;
        mem_hold = 0; rnd = 0; live_chk = 0;
        mq_a.delete(); mq_t.delete();
        cycle();
        cycle();
        reqs.delete(); got_pc.delete(); got_inst.delete();
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;

        // Reset start and in-order streaming
        do_reset();
        chk("rst_req", 64'(s_req), 64'(0));
        chk("rst_vld", 64'(s_valid), 64'(0));
        inst_addr_ok = 1'b1; ds_allow_in = 1'b1;
        cycle();
        chk("t1_req0", 64'(s_req), 64'(1));
        chk("t1_addr0", 64'(s_addr), 64'(BASE));
        cycle();
        chk("t1_dok", 64'(s_dok), 64'(1));
        chk("t1_lat0", 64'(s_valid), 64'(BYP));
        cycle();
        chk("t1_lat1", 64'(s_valid), 64'(1));
        repeat (10) cycle();
        for (int i = 0; i < 8; i++) begin
            chk("t1_req", 64'(reqs[i]), 64'(BASE + 32'(4 * i)));
            chk("t1_pc", 64'(got_pc[i]), 64'(BASE + 32'(4 * i)));
            chk("t1_inst", 64'(got_inst[i]), 64'((BASE + 32'(4 * i)) ^ KEY));
        end

        // Full stall then a single pop
        do_reset();
        inst_addr_ok = 1'b1; ds_allow_in = 1'b0;
        repeat (10) cycle();
        chk("t2_nreq", 64'(reqs.size()), 64'(4));
        chk("t2_req_lo", 64'(s_req), 64'(0));
        chk("t2_vld", 64'(s_valid), 64'(1));
        for (int i = 0; i < 4; i++)
            chk("t2_addr", 64'(reqs[i]), 64'(BASE + 32'(4 * i)));
        ds_allow_in = 1'b1;
        cycle();
        chk("t2_req_pop", 64'(s_req), 64'(0));
        ds_allow_in = 1'b0;
        repeat (5) cycle();
        chk("t2_nreq5", 64'(reqs.size()), 64'(5));
        chk("t2_addr5", 64'(reqs[4]), 64'(BASE + 32'd16));
        chk("t2_ngot", 64'(got_pc.size()), 64'(1));
        chk("t2_pc0", 64'(got_pc[0]), 64'(BASE));

        // Branch with two fetches in flight
        do_reset();
        inst_addr_ok = 1'b1; ds_allow_in = 1'b1; mem_hold = 1;
        cycle();
        cycle();
        br_bus = {1'b1, 32'h1c000100};
        cycle();
        chk("t3_req_br", 64'(s_req), 64'(0));
        br_bus = '0; mem_hold = 0;
        cycle();
        chk("t3_req_after", 64'(s_req), 64'(1));
        chk("t3_addr_after", 64'(s_addr), 64'h1c000100);
        repeat (10) cycle();
        chk("t3_pc0", 64'(got_pc[0]), 64'h1c000100);
        chk("t3_inst0", 64'(got_inst[0]), 64'(32'h1c000100 ^ KEY));
        chk("t3_pc1", 64'(got_pc[1]), 64'h1c000104);

        // Branch in the same cycle as a response, three pending
        do_reset();
        inst_addr_ok = 1'b1; ds_allow_in = 1'b1; mem_hold = 1;
        repeat (3) cycle();
        br_bus = {1'b1, 32'h1c000200}; mem_hold = 0;
        cycle();
        chk("t4_dok", 64'(s_dok), 64'(1));
        chk("t4_req_br", 64'(s_req), 64'(0));
        br_bus = '0; mem_hold = 1;
        n0 = reqs.size();
        repeat (6) cycle();
        chk("t4_nreq", 64'(reqs.size() - n0), 64'(2));
        chk("t4_req_lo", 64'(s_req), 64'(0));
        chk("t4_addr", 64'(reqs[n0]), 64'h1c000200);
        mem_hold = 0;
        repeat (10) cycle();
        chk("t4_pc0", 64'(got_pc[0]), 64'h1c000200);
        chk("t4_pc1", 64'(got_pc[1]), 64'h1c000204);

        // Random handshakes with periodic branches
        do_reset();
        rnd = 1; live_chk = 1; exp_pc = BASE;
        for (int k = 0; k < 400; k++) begin
            if (k % 53 == 52) begin
                tgt = 32'h1c001000 + 32'(k * 16);
                br_bus = {1'b1, tgt};
                exp_pc = tgt;
                cycle();
                br_bus = '0;
            end else begin
                cycle();
            end
        end
        rnd = 0; live_chk = 0;
        chk("t5_progress", 64'(got_pc.size() > 50), 64'(1));

        // Reset with a full buffer and stale responses outstanding
        do_reset();
        inst_addr_ok = 1'b1; ds_allow_in = 1'b1; mem_hold = 1;
        cycle();
        cycle();
        br_bus = {1'b1, 32'h1c000100};
        cycle();
        br_bus = '0;
        repeat (4) cycle();
        chk("t6_full", 64'(s_req), 64'(0));
        do_reset();
        chk("t6_rst_req", 64'(s_req), 64'(0));
        chk("t6_rst_vld", 64'(s_valid), 64'(0));
        inst_addr_ok = 1'b1; ds_allow_in = 1'b1;
        cycle();
        chk("t6_vld0", 64'(s_valid), 64'(0));
        chk("t6_req0", 64'(s_req), 64'(1));
        chk("t6_addr0", 64'(s_addr), 64'(BASE));
        repeat (6) cycle();
        chk("t6_pc0", 64'(got_pc[0]), 64'(BASE));
        chk("t6_inst0", 64'(got_inst[0]), 64'(BASE ^ KEY));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
